usb_tx_pkt_seq: RTL and testbench
=================================

USB_TX_PKT_SEQ -- requirements
Module: usb_tx_pkt_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 n_rst  in  1  asynchronous, active-low reset.
REQ-003 tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-004 tx_packet  in  4  PID nibble to send: DATA0=1100, DATA1=1101, ACK=0100, NAK=0101, STALL=0111.
REQ-005 buffer_occupancy  in  7  payload byte count; latched on tx_start.
REQ-006 tx_data  in  8  show-ahead TX FIFO head byte.
REQ-007 get_tx_data  out  1  one-cycle FIFO pop strobe.
REQ-008 byte_ready  in  1  serializer accepts tx_byte in the current cycle.
REQ-009 tx_byte  out  8  byte presented to the serializer.
REQ-010 tx_byte_valid  out  1  tx_byte is valid; a transfer occurs when tx_byte_valid and byte_ready are both high.
REQ-011 send_eop  out  1  request to the serializer to drive EOP.
REQ-012 eop_done  in  1  serializer has finished EOP.
REQ-013 tx_busy  out  1  high in every state except IDLE.
REQ-014 tx_done  out  1  one-cycle pulse at packet completion.
REQ-015 tx_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-016 FSM states SHALL be IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
REQ-017 In IDLE, tx_start with a valid tx_packet SHALL latch tx_packet and the byte count, clear the CRC to 0xFFFF and enter SYNC next cycle.
REQ-018 In IDLE, tx_start with an invalid PID, or with a DATA PID and count >64, SHALL pulse tx_err the next cycle and remain in IDLE.
REQ-019 SYNC SHALL present 0x80; PID SHALL present {pid, ~pid}, e.g. DATA0 gives 0xC3 and ACK gives 0x4B.
REQ-020 Each state SHALL hold tx_byte_valid and tx_byte stable until a transfer, then advance on the next edge.
REQ-021 Sequence after PID: for ACK/NAK/STALL go to EOP; for DATA with count >0 go to DATA; for DATA with count 0 go to CRC_LO.
REQ-022 DATA SHALL drive tx_byte=tx_data and pulse get_tx_data on each transfer cycle.
REQ-023 DATA SHALL decrement a 7-bit remaining counter per transfer and go to CRC_LO when the count reaches 0.
REQ-024 CRC16 SHALL use the reflected polynomial 0xA001, processed LSB-first, init 0xFFFF, updated on each DATA transfer.
REQ-025 CRC_LO SHALL present ~crc[7:0]; CRC_HI SHALL present ~crc[15:8].
REQ-026 EOP SHALL hold send_eop high with tx_byte_valid low until eop_done, then enter DONE.
REQ-027 DONE SHALL pulse tx_done for one cycle, then return to IDLE.
REQ-028 tx_start outside IDLE SHALL be ignored, with no tx_err.
REQ-029 byte_ready while tx_byte_valid is low SHALL be ignored.
REQ-030 eop_done outside EOP SHALL be ignored.
REQ-031 get_tx_data SHALL never assert outside DATA.
REQ-032 Latency: tx_start accepted at cycle N gives tx_byte_valid=1, tx_byte=0x80 at cycle N+1.

Reset
REQ-033 n_rst low SHALL immediately force IDLE, crc=0xFFFF, counter=0 and tx_byte=0x00.
REQ-034 n_rst low SHALL immediately force all 1-bit outputs low.
REQ-035 Reset mid-packet SHALL abandon the packet with no EOP and no tx_done.
REQ-036 No FIFO pop SHALL occur during reset or in the first cycle after reset release.

Configuration
REQ-037 Macro TX_STALL_EN: when defined, STALL (0111) SHALL be a valid handshake PID sent as 0x78.
REQ-038 When TX_STALL_EN is undefined, STALL SHALL be rejected per REQ-018 with a tx_err pulse.
REQ-039 All other behaviour SHALL be identical with and without TX_STALL_EN.

Verification
REQ-040 ACK, byte_ready tied high, eop_done after 3 cycles -> bytes 0x80, 0x4B, then send_eop for 3 cycles, then a single tx_done.
REQ-041 DATA0, count 0 -> bytes 0x80, 0xC3, 0x00, 0x00, then EOP, with no get_tx_data pulse.
REQ-042 DATA1, count 9, FIFO "123456789" -> bytes 0x80, 0xD2, 0x31..0x39, 0xC8, 0xB4, with exactly 9 get_tx_data pulses.
REQ-043 DATA0, count 3, byte_ready stalls of 0-4 cycles -> same byte stream, with tx_byte stable for the full duration of every stall.
REQ-044 tx_packet=0110, or DATA0 with count 65 -> tx_err pulse at cycle N+1, tx_busy remains 0 and no bytes are sent.
REQ-045 n_rst asserted during the DATA byte 2 transfer -> all outputs 0 at once, then a fresh ACK packet completes normally.

Source files
------------

// File: rtl/usb_tx_pkt_seq.sv
// USB transmit packet sequencer: SYNC, PID, optional payload with CRC16, then EOP.
// Define TX_STALL_EN to accept STALL (0111) as a handshake PID.
module usb_tx_pkt_seq (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_data,
    output logic       get_tx_data,
    input  logic       byte_ready,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    output logic       send_eop,
    input  logic       eop_done,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam logic [3:0]  PID_DATA0   = 4'b1100;
    localparam logic [3:0]  PID_DATA1   = 4'b1101;
    localparam logic [3:0]  PID_ACK     = 4'b0100;
    localparam logic [3:0]  PID_NAK     = 4'b0101;
`ifdef TX_STALL_EN
    localparam logic [3:0]  PID_STALL   = 4'b0111;
`endif
    localparam logic [6:0]  MAX_PAYLOAD = 7'd64;
    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC_LO,
        CRC_HI,
        EOP,
        DONE
    } state_t;

    state_t      state_reg;
    logic [3:0]  pid_reg;
    logic [6:0]  remaining_reg;
    logic [15:0] crc_reg;
    logic [7:0]  tx_byte_reg;
    logic        tx_byte_valid_reg;
    logic        send_eop_reg;
    logic        tx_busy_reg;
    logic        tx_done_reg;
    logic        tx_err_reg;

    logic        req_is_data;
    logic        req_is_handshake;
    logic        req_ok;
    logic        pid_is_data;
    logic        transfer;
    logic [15:0] crc_next;

    // One byte of reflected CRC16, consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        req_is_data = (tx_packet == PID_DATA0) || (tx_packet == PID_DATA1);
`ifdef TX_STALL_EN
        req_is_handshake = (tx_packet == PID_ACK) || (tx_packet == PID_NAK) || (tx_packet == PID_STALL);
`else
        req_is_handshake = (tx_packet == PID_ACK) || (tx_packet == PID_NAK);
`endif
        req_ok      = req_is_handshake || (req_is_data && (buffer_occupancy <= MAX_PAYLOAD));
        pid_is_data = (pid_reg[3:1] == 3'b110);
        transfer    = tx_byte_valid_reg && byte_ready;
        crc_next    = crc16_byte(crc_reg, tx_data);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg         <= IDLE;
            pid_reg           <= 4'h0;
            remaining_reg     <= 7'd0;
            crc_reg           <= CRC_INIT;
            tx_byte_reg       <= 8'h00;
            tx_byte_valid_reg <= 1'b0;
            send_eop_reg      <= 1'b0;
            tx_busy_reg       <= 1'b0;
            tx_done_reg       <= 1'b0;
            tx_err_reg        <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            tx_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_start) begin
                        if (req_ok) begin
                            pid_reg           <= tx_packet;
                            remaining_reg     <= buffer_occupancy;
                            crc_reg           <= CRC_INIT;
                            tx_byte_reg       <= SYNC_BYTE;
                            tx_byte_valid_reg <= 1'b1;
                            tx_busy_reg       <= 1'b1;
                            state_reg         <= SYNC;
                        end else begin
                            tx_err_reg <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (transfer) begin
                        tx_byte_reg <= {pid_reg, ~pid_reg};
                        state_reg   <= PID;
                    end
                end
                PID: begin
                    if (transfer) begin
                        if (!pid_is_data) begin
                            tx_byte_valid_reg <= 1'b0;
                            tx_byte_reg       <= 8'h00;
                            send_eop_reg      <= 1'b1;
                            state_reg         <= EOP;
                        end else if (remaining_reg != 7'd0) begin
                            tx_byte_reg <= 8'h00;
                            state_reg   <= DATA;
                        end else begin
                            tx_byte_reg <= ~crc_reg[7:0];
                            state_reg   <= CRC_LO;
                        end
                    end
                end
                DATA: begin
                    // tx_byte comes straight from the FIFO head here; the CRC low byte
                    // must use the CRC that includes the final payload byte.
                    if (transfer) begin
                        crc_reg       <= crc_next;
                        remaining_reg <= remaining_reg - 7'd1;
                        if (remaining_reg == 7'd1) begin
                            tx_byte_reg <= ~crc_next[7:0];
                            state_reg   <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (transfer) begin
                        tx_byte_reg <= ~crc_reg[15:8];
                        state_reg   <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (transfer) begin
                        tx_byte_valid_reg <= 1'b0;
                        tx_byte_reg       <= 8'h00;
                        send_eop_reg      <= 1'b1;
                        state_reg         <= EOP;
                    end
                end
                EOP: begin
                    if (eop_done) begin
                        send_eop_reg <= 1'b0;
                        tx_done_reg  <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    tx_busy_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_byte       = (state_reg == DATA) ? tx_data : tx_byte_reg;
    assign get_tx_data   = (state_reg == DATA) && transfer;
    assign tx_byte_valid = tx_byte_valid_reg;
    assign send_eop      = send_eop_reg;
    assign tx_busy       = tx_busy_reg;
    assign tx_done       = tx_done_reg;
    assign tx_err        = tx_err_reg;

endmodule

// File: tb/tb_usb_tx_pkt_seq.sv
// Bench for usb_tx_pkt_seq: directed packets, stalls, rejects, mid-packet reset and
// random packets checked against a byte-stream reference model.
module tb_usb_tx_pkt_seq;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [3:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_data;
    logic       get_tx_data;
    logic       byte_ready;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       send_eop;
    logic       eop_done;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    usb_tx_pkt_seq dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .tx_start         (tx_start),
        .tx_packet        (tx_packet),
        .buffer_occupancy (buffer_occupancy),
        .tx_data          (tx_data),
        .get_tx_data      (get_tx_data),
        .byte_ready       (byte_ready),
        .tx_byte          (tx_byte),
        .tx_byte_valid    (tx_byte_valid),
        .send_eop         (send_eop),
        .eop_done         (eop_done),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .tx_err           (tx_err)
    );

    always #5 clk = ~clk;

`ifdef TX_STALL_EN
    localparam bit STALL_OK = 1'b1;
`else
    localparam bit STALL_OK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int pop_cnt, eop_cnt, done_cnt, err_cnt, stab_err, pop_bad;
    int ready_mode = 0;
    int eop_delay  = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        obs_q.delete();
        pop_cnt = 0; eop_cnt = 0; done_cnt = 0; err_cnt = 0; stab_err = 0; pop_bad = 0;
    endtask

    // Monitor: record transfers and protocol events, away from the active edge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_byte;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_byte_valid && byte_ready) obs_q.push_back(tx_byte);
            if (get_tx_data) pop_cnt++;
            if (get_tx_data && !(tx_byte_valid && byte_ready)) pop_bad++;
            if (send_eop) eop_cnt++;
            if (send_eop && tx_byte_valid) stab_err++;
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (prev_stall && !(tx_byte_valid && tx_byte == prev_byte)) stab_err++;
            prev_stall = n_rst && tx_byte_valid && !byte_ready;
            prev_byte  = tx_byte;
        end
    end

    // Environment: show-ahead FIFO, serializer ready, EOP completion.
    initial begin
        int   stall_left;
        int   eop_seen;
        logic pop;
        stall_left = 0;
        eop_seen   = 0;
        byte_ready = 1'b0;
        eop_done   = 1'b0;
        tx_data    = 8'h00;
        forever begin
            @(negedge clk);
            pop = get_tx_data;
            @(posedge clk);
            #1;
            if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            tx_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
            if (ready_mode == 0) begin
                byte_ready = 1'b1;
            end else if (stall_left > 0) begin
                byte_ready = 1'b0;
                stall_left--;
            end else begin
                byte_ready = 1'b1;
                stall_left = $urandom_range(0, 4);
            end
            if (send_eop) begin
                eop_seen++;
                eop_done = (eop_seen >= eop_delay);
            end else begin
                eop_seen = 0;
                eop_done = ($urandom_range(0, 3) == 0);
            end
        end
    end

    function automatic bit is_data_pid(input logic [3:0] p);
        return (p == 4'hC) || (p == 4'hD);
    endfunction

    function automatic bit pid_accepted(input logic [3:0] p, input int cnt);
        bit hs;
        hs = (p == 4'h4) || (p == 4'h5) || (STALL_OK && p == 4'h7);
        return hs || (is_data_pid(p) && cnt <= 64);
    endfunction

    // Reference byte stream: SYNC, PID|~PID, payload, complemented CRC16/USB low then high.
    task automatic build_expected(input logic [3:0] p, input int cnt);
        int pv;
        int crc;
        exp_q.delete();
        if (!pid_accepted(p, cnt)) return;
        pv = int'(p);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'(pv * 16 + (15 - pv)));
        if (is_data_pid(p)) begin
            crc = 'hFFFF;
            for (int i = 0; i < cnt; i++) begin
                exp_q.push_back(fifo_q[i]);
                crc = crc ^ int'(fifo_q[i]);
                for (int b = 0; b < 8; b++)
                    crc = (crc % 2 == 1) ? ((crc / 2) ^ 'hA001) : (crc / 2);
            end
            crc = crc ^ 'hFFFF;
            exp_q.push_back(8'(crc % 256));
            exp_q.push_back(8'(crc / 256));
        end
    endtask

    task automatic run_packet(input string tag, input logic [3:0] p, input int cnt,
                              input int rmode, input int edelay);
        bit ok;
        int exp_pops;
        bit finished;
        ok       = pid_accepted(p, cnt);
        exp_pops = (ok && is_data_pid(p)) ? cnt : 0;
        @(posedge clk);
        #2;
        ready_mode = rmode;
        eop_delay  = edelay;
        clear_counters();
        tx_start         = 1'b1;
        tx_packet        = p;
        buffer_occupancy = 7'(cnt);
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        if (ok) begin
            check({tag, " first valid"}, 32'(tx_byte_valid), 1);
            check({tag, " first byte"}, 32'(tx_byte), 32'h80);
            check({tag, " busy"}, 32'(tx_busy), 1);
            check({tag, " no err"}, 32'(tx_err), 0);
            finished = 1'b0;
            for (int c = 0; c < 2000 && !finished; c++) begin
                @(negedge clk);
                if (done_cnt > 0 && !tx_busy) finished = 1'b1;
                tx_start         = !finished && tx_busy && ($urandom_range(0, 3) == 0);
                tx_packet        = 4'($urandom);
                buffer_occupancy = 7'($urandom);
            end
            tx_start = 1'b0;
            check({tag, " completes"}, 32'(finished), 1);
            repeat (3) @(negedge clk);
            check({tag, " byte count"}, obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                check($sformatf("%s byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
            check({tag, " pops"}, pop_cnt, exp_pops);
            check({tag, " tx_done pulses"}, done_cnt, 1);
            check({tag, " eop cycles"}, eop_cnt, edelay);
            check({tag, " tx_err pulses"}, err_cnt, 0);
            check({tag, " stability"}, stab_err, 0);
            check({tag, " stray pops"}, pop_bad, 0);
            check({tag, " idle busy"}, 32'(tx_busy), 0);
        end else begin
            check({tag, " err pulse"}, 32'(tx_err), 1);
            check({tag, " err busy"}, 32'(tx_busy), 0);
            check({tag, " err valid"}, 32'(tx_byte_valid), 0);
            @(posedge clk);
            #2;
            check({tag, " err one cycle"}, 32'(tx_err), 0);
            check({tag, " err still idle"}, 32'(tx_busy), 0);
            repeat (4) @(negedge clk);
            check({tag, " err no bytes"}, obs_q.size(), 0);
            check({tag, " err count"}, err_cnt, 1);
            check({tag, " err no pops"}, pop_cnt, 0);
            check({tag, " err no done"}, done_cnt, 0);
            check({tag, " err no eop"}, eop_cnt, 0);
        end
        $display("pkt %-16s pid=%h cnt=%0d bytes=%0d pops=%0d", tag, p, cnt, obs_q.size(), pop_cnt);
    endtask

    initial begin
        logic [3:0] pid_tab[6];
        logic [3:0] p;
        int         cnt;
        bit         got;

        pid_tab[0] = 4'hC; pid_tab[1] = 4'hD; pid_tab[2] = 4'h4;
        pid_tab[3] = 4'h5; pid_tab[4] = 4'h7; pid_tab[5] = 4'h6;
        n_rst = 1'b0;
        tx_start = 1'b0;
        tx_packet = 4'h0;
        buffer_occupancy = 7'd0;
        #3;
        check("reset tx_byte", 32'(tx_byte), 0);
        check("reset valid", 32'(tx_byte_valid), 0);
        check("reset busy", 32'(tx_busy), 0);
        check("reset pop", 32'(get_tx_data), 0);
        check("reset eop", 32'(send_eop), 0);
        check("reset done", 32'(tx_done), 0);
        check("reset err", 32'(tx_err), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        exp_q = {8'h80, 8'h4B};
        run_packet("ack", 4'h4, 0, 0, 3);

        exp_q = {8'h80, 8'hC3, 8'h00, 8'h00};
        run_packet("data0_empty", 4'hC, 0, 0, 2);

        fifo_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q  = {8'h80, 8'hD2, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'hC8, 8'hB4};
        run_packet("data1_digits", 4'hD, 9, 0, 1);

        for (int k = 0; k < 2; k++) begin
            fifo_q.delete();
            for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
            build_expected(4'hC, 3);
            run_packet("data0_stalls", 4'hC, 3, 1, 2);
        end

        fifo_q.delete();
        exp_q.delete();
        run_packet("bad_pid", 4'h6, 0, 0, 1);
        run_packet("data0_65", 4'hC, 65, 0, 1);

        if (STALL_OK) exp_q = {8'h80, 8'h78};
        else exp_q.delete();
        run_packet("stall", 4'h7, 0, 0, 2);

        fifo_q.delete();
        for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
        build_expected(4'hD, 64);
        run_packet("data1_64", 4'hD, 64, 1, 4);

        // Reset while the second payload byte is being offered.
        fifo_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        @(posedge clk);
        #2;
        ready_mode = 0;
        clear_counters();
        tx_start = 1'b1;
        tx_packet = 4'hC;
        buffer_occupancy = 7'd5;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #2;
            if (obs_q.size() >= 3) got = 1'b1;
        end
        check("rst reach byte2", 32'(got), 1);
        check("rst byte2 value", 32'(tx_byte), 32'hA2);
        check("rst byte2 pop", 32'(get_tx_data), 1);
        n_rst = 1'b0;
        #1;
        check("rst tx_byte", 32'(tx_byte), 0);
        check("rst valid", 32'(tx_byte_valid), 0);
        check("rst busy", 32'(tx_busy), 0);
        check("rst pop", 32'(get_tx_data), 0);
        check("rst eop", 32'(send_eop), 0);
        check("rst done", 32'(tx_done), 0);
        check("rst err", 32'(tx_err), 0);
        clear_counters();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst abandoned done", done_cnt, 0);
        check("rst abandoned eop", eop_cnt, 0);
        check("rst no pops", pop_cnt, 0);
        check("rst idle busy", 32'(tx_busy), 0);
        fifo_q.delete();
        exp_q = {8'h80, 8'h4B};
        run_packet("ack_after_rst", 4'h4, 0, 0, 2);

        for (int k = 0; k < 10; k++) begin
            p = pid_tab[$urandom_range(0, 5)];
            if (k % 4 == 3) p = 4'($urandom);
            cnt = is_data_pid(p) ? $urandom_range(0, 66) : $urandom_range(0, 127);
            fifo_q.delete();
            for (int i = 0; i < cnt; i++) fifo_q.push_back(8'($urandom));
            build_expected(p, cnt);
            run_packet($sformatf("rand%0d", k), p, cnt, $urandom_range(0, 1), $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
